// File: rtl/sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_ctrl
// Purpose  : Arbitrates decoded SNES and SA1 memory requests and runs timed
//            read/write cycles on the 16-bit external SRAM0 (ROM + SaveRAM).
//            SNES requests are strobes held in a one-deep latch and always
//            win arbitration; SA1 requests are level-held until acknowledged.
// Revision : 1.0  initial release
// ============================================================================
module sram_access_ctrl #(
    parameter int RD_CYCLES    = 5,
    parameter int WR_CYCLES    = 4,
    parameter int RECOV_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        snes_req,
    input  logic [23:0] snes_addr,
    input  logic        snes_we,
    input  logic        snes_writable,
    input  logic [7:0]  snes_wdata,
    output logic [7:0]  snes_rdata,
    output logic        snes_done,
    input  logic        sa1_req,
    input  logic [23:0] sa1_addr,
    input  logic        sa1_we,
    input  logic [7:0]  sa1_wdata,
    output logic [7:0]  sa1_rdata,
    output logic        sa1_ack,
    output logic        busy,
    output logic [22:0] ROM_ADDR,
    output logic [15:0] ROM_DQ_OUT,
    input  logic [15:0] ROM_DQ_IN,
    output logic        ROM_DQ_OE,
    output logic        ROM_CE_N,
    output logic        ROM_OE_N,
    output logic        ROM_WE_N,
    output logic        ROM_BHE_N,
    output logic        ROM_BLE_N
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RECOV = 2'd3
    } state_t;

    // Cycle counter is 4 bits wide, so all timing parameters must be 1..15.
    localparam logic [3:0] C_RD_LAST    = 4'(RD_CYCLES);
    localparam logic [3:0] C_WR_LAST    = 4'(WR_CYCLES);
    localparam logic [3:0] C_RECOV_LAST = 4'(RECOV_CYCLES);

    state_t      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic        owner_sa1_q,  owner_sa1_d;
    logic        lane_hi_q,    lane_hi_d;
    logic        snes_pend_q,  snes_pend_d;
    logic [23:0] pend_addr_q,  pend_addr_d;
    logic        pend_we_q,    pend_we_d;
    logic [7:0]  pend_wdata_q, pend_wdata_d;
    logic [22:0] rom_addr_q,   rom_addr_d;
    logic [15:0] dq_out_q,     dq_out_d;
    logic        dq_oe_q,      dq_oe_d;
    logic        ce_n_q,       ce_n_d;
    logic        oe_n_q,       oe_n_d;
    logic        we_n_q,       we_n_d;
    logic        bhe_n_q,      bhe_n_d;
    logic        ble_n_q,      ble_n_d;
    logic [7:0]  snes_rdata_q, snes_rdata_d;
    logic [7:0]  sa1_rdata_q,  sa1_rdata_d;
    logic        snes_done_q,  snes_done_d;
    logic        sa1_ack_q,    sa1_ack_d;

    logic        sel_valid;
    logic        sel_sa1;
    logic [23:0] sel_addr;
    logic        sel_we;
    logic [7:0]  sel_wdata;
    logic [7:0]  rd_byte;

    // Arbitration: a fresh SNES strobe beats the latched one, SNES beats SA1
    always_comb begin
        sel_valid = 1'b0;
        sel_sa1   = 1'b0;
        sel_addr  = pend_addr_q;
        sel_we    = pend_we_q;
        sel_wdata = pend_wdata_q;
        if (snes_req) begin
            sel_valid = 1'b1;
            sel_addr  = snes_addr;
            sel_we    = snes_we & snes_writable;
            sel_wdata = snes_wdata;
        end else if (snes_pend_q) begin
            sel_valid = 1'b1;
        end else if (sa1_req) begin
            sel_valid = 1'b1;
            sel_sa1   = 1'b1;
            sel_addr  = sa1_addr;
            sel_we    = sa1_we;
            sel_wdata = sa1_wdata;
        end
    end

    assign rd_byte = lane_hi_q ? ROM_DQ_IN[15:8] : ROM_DQ_IN[7:0];

    // Access sequencing, SRAM strobes and SNES pending latch
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_sa1_d  = owner_sa1_q;
        lane_hi_d    = lane_hi_q;
        snes_pend_d  = snes_pend_q;
        pend_addr_d  = pend_addr_q;
        pend_we_d    = pend_we_q;
        pend_wdata_d = pend_wdata_q;
        rom_addr_d   = rom_addr_q;
        dq_out_d     = dq_out_q;
        dq_oe_d      = dq_oe_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        bhe_n_d      = bhe_n_q;
        ble_n_d      = ble_n_q;
        snes_rdata_d = snes_rdata_q;
        sa1_rdata_d  = sa1_rdata_q;
        snes_done_d  = 1'b0;
        sa1_ack_d    = 1'b0;

        // Write protection is folded in at capture time; last strobe wins.
        if (snes_req) begin
            snes_pend_d  = 1'b1;
            pend_addr_d  = snes_addr;
            pend_we_d    = snes_we & snes_writable;
            pend_wdata_d = snes_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    if (!sel_sa1) begin
                        snes_pend_d = 1'b0;
                    end
                    owner_sa1_d = sel_sa1;
                    rom_addr_d  = sel_addr[23:1];
                    lane_hi_d   = sel_addr[0];
                    bhe_n_d     = ~sel_addr[0];
                    ble_n_d     = sel_addr[0];
                    ce_n_d      = 1'b0;
                    cnt_d       = 4'd0;
                    if (sel_we) begin
                        state_d  = ST_WRITE;
                        dq_oe_d  = 1'b1;
                        dq_out_d = {sel_wdata, sel_wdata};
                    end else begin
                        state_d  = ST_READ;
                    end
                end
            end
            // Count 0 is the address setup cycle; counts 1..last hold OE_N low.
            ST_READ: begin
                oe_n_d = 1'b0;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == C_RD_LAST) begin
                    oe_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    bhe_n_d = 1'b1;
                    ble_n_d = 1'b1;
                    cnt_d   = 4'd1;
                    state_d = ST_RECOV;
                    if (owner_sa1_q) begin
                        sa1_rdata_d = rd_byte;
                        sa1_ack_d   = sa1_req;
                    end else begin
                        snes_rdata_d = rd_byte;
                        snes_done_d  = 1'b1;
                    end
                end
            end
            // DQ_OE stays up into the first recovery cycle for data hold time.
            ST_WRITE: begin
                we_n_d = 1'b0;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == C_WR_LAST) begin
                    we_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    bhe_n_d = 1'b1;
                    ble_n_d = 1'b1;
                    cnt_d   = 4'd1;
                    state_d = ST_RECOV;
                    if (owner_sa1_q) begin
                        sa1_ack_d = sa1_req;
                    end else begin
                        snes_done_d = 1'b1;
                    end
                end
            end
            default: begin
                dq_oe_d = 1'b0;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == C_RECOV_LAST) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and registered outputs; reset drops every strobe immediately
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            owner_sa1_q  <= 1'b0;
            lane_hi_q    <= 1'b0;
            snes_pend_q  <= 1'b0;
            pend_addr_q  <= 24'd0;
            pend_we_q    <= 1'b0;
            pend_wdata_q <= 8'd0;
            rom_addr_q   <= 23'd0;
            dq_out_q     <= 16'd0;
            dq_oe_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            bhe_n_q      <= 1'b1;
            ble_n_q      <= 1'b1;
            snes_rdata_q <= 8'd0;
            sa1_rdata_q  <= 8'd0;
            snes_done_q  <= 1'b0;
            sa1_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_sa1_q  <= owner_sa1_d;
            lane_hi_q    <= lane_hi_d;
            snes_pend_q  <= snes_pend_d;
            pend_addr_q  <= pend_addr_d;
            pend_we_q    <= pend_we_d;
            pend_wdata_q <= pend_wdata_d;
            rom_addr_q   <= rom_addr_d;
            dq_out_q     <= dq_out_d;
            dq_oe_q      <= dq_oe_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            bhe_n_q      <= bhe_n_d;
            ble_n_q      <= ble_n_d;
            snes_rdata_q <= snes_rdata_d;
            sa1_rdata_q  <= sa1_rdata_d;
            snes_done_q  <= snes_done_d;
            sa1_ack_q    <= sa1_ack_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign ROM_ADDR   = rom_addr_q;
    assign ROM_DQ_OUT = dq_out_q;
    assign ROM_DQ_OE  = dq_oe_q;
    assign ROM_CE_N   = ce_n_q;
    assign ROM_OE_N   = oe_n_q;
    assign ROM_WE_N   = we_n_q;
    assign ROM_BHE_N  = bhe_n_q;
    assign ROM_BLE_N  = ble_n_q;
    assign snes_rdata = snes_rdata_q;
    assign snes_done  = snes_done_q;
    assign sa1_rdata  = sa1_rdata_q;
    assign sa1_ack    = sa1_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_access_ctrl
// Purpose  : Self-checking bench for sram_access_ctrl with an SRAM pin model
//            and a transaction-level expectation of memory contents/latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_access_ctrl;

    localparam int RD = 5;
    localparam int WR = 4;
    localparam int RC = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snes_req = 1'b0;
    logic [23:0] snes_addr = 24'd0;
    logic        snes_we = 1'b0;
    logic        snes_writable = 1'b0;
    logic [7:0]  snes_wdata = 8'd0;
    logic        sa1_req = 1'b0;
    logic [23:0] sa1_addr = 24'd0;
    logic        sa1_we = 1'b0;
    logic [7:0]  sa1_wdata = 8'd0;

    wire [7:0]  snes_rdata;
    wire        snes_done;
    wire [7:0]  sa1_rdata;
    wire        sa1_ack;
    wire        busy;
    wire [22:0] rom_addr;
    wire [15:0] rom_dq_out;
    wire [15:0] rom_dq_in;
    wire        rom_dq_oe;
    wire        rom_ce_n, rom_oe_n, rom_we_n, rom_bhe_n, rom_ble_n;

    int checks = 0;
    int failures = 0;

    // SRAM model contents (driven through pins) and expected contents
    logic [15:0] mem     [0:255];
    logic [15:0] exp_mem [0:255];
    logic        mem_load = 1'b0;

    sram_access_ctrl #(.RD_CYCLES(RD), .WR_CYCLES(WR), .RECOV_CYCLES(RC)) dut (
        .CLK(clk), .RST_N(rst_n),
        .snes_req(snes_req), .snes_addr(snes_addr), .snes_we(snes_we),
        .snes_writable(snes_writable), .snes_wdata(snes_wdata),
        .snes_rdata(snes_rdata), .snes_done(snes_done),
        .sa1_req(sa1_req), .sa1_addr(sa1_addr), .sa1_we(sa1_we),
        .sa1_wdata(sa1_wdata), .sa1_rdata(sa1_rdata), .sa1_ack(sa1_ack),
        .busy(busy),
        .ROM_ADDR(rom_addr), .ROM_DQ_OUT(rom_dq_out), .ROM_DQ_IN(rom_dq_in),
        .ROM_DQ_OE(rom_dq_oe), .ROM_CE_N(rom_ce_n), .ROM_OE_N(rom_oe_n),
        .ROM_WE_N(rom_we_n), .ROM_BHE_N(rom_bhe_n), .ROM_BLE_N(rom_ble_n)
    );

    always #5 clk = ~clk;

    // Data only valid while OE_N is low; a marker value otherwise
    assign rom_dq_in = (!rom_oe_n) ? mem[rom_addr[7:0]] : 16'hDEAD;

    // SRAM write behaviour: lanes written while CE_N and WE_N are low
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= exp_mem[i];
        end else if (!rom_ce_n && !rom_we_n && rom_dq_oe) begin
            if (!rom_ble_n) mem[rom_addr[7:0]][7:0]  <= rom_dq_out[7:0];
            if (!rom_bhe_n) mem[rom_addr[7:0]][15:8] <= rom_dq_out[15:8];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++; failures++;
            $display("FAIL wait_idle busy got=%b exp=0", busy);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [23:0] a);
        logic [15:0] w;
        w = exp_mem[a[8:1]];
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    function automatic void exp_write(input logic [23:0] a, input logic [7:0] d);
        if (a[0]) exp_mem[a[8:1]][15:8] = d;
        else      exp_mem[a[8:1]][7:0]  = d;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        mem_load = 1'b1;
        step(); step();
        mem_load = 1'b0;
        checks++;
        if ({rom_ce_n, rom_oe_n, rom_we_n, rom_bhe_n, rom_ble_n} !== 5'b11111) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=11111",
                     {rom_ce_n, rom_oe_n, rom_we_n, rom_bhe_n, rom_ble_n});
        end
        checks++;
        if (rom_dq_oe !== 1'b0 || rom_addr !== 23'd0 || rom_dq_out !== 16'd0) begin
            failures++;
            $display("FAIL reset_bus got oe=%b addr=%h dq=%h exp 0/0/0", rom_dq_oe, rom_addr, rom_dq_out);
        end
        checks++;
        if (snes_rdata !== 8'd0 || sa1_rdata !== 8'd0) begin
            failures++;
            $display("FAIL reset_rdata got snes=%h sa1=%h exp 00/00", snes_rdata, sa1_rdata);
        end
        checks++;
        if (snes_done !== 1'b0 || sa1_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got done=%b ack=%b busy=%b exp 000", snes_done, sa1_ack, busy);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_snes_read();
        int lat, oe_low;
        wait_idle();
        snes_addr = 24'h000123; snes_we = 1'b0; snes_writable = 1'b0; snes_req = 1'b1;
        step();
        snes_req = 1'b0;
        checks++;
        if (rom_addr !== 23'h000091 || rom_bhe_n !== 1'b0 || rom_ble_n !== 1'b1 || rom_ce_n !== 1'b0) begin
            failures++;
            $display("FAIL read_setup got addr=%h bhe=%b ble=%b ce=%b exp 000091/0/1/0",
                     rom_addr, rom_bhe_n, rom_ble_n, rom_ce_n);
        end
        lat = 1; oe_low = 0;
        while (snes_done !== 1'b1 && lat < 40) begin
            if (!rom_oe_n) oe_low++;
            step();
            lat++;
        end
        checks++;
        if (lat != RD + 2) begin
            failures++;
            $display("FAIL read_latency got=%0d exp=%0d", lat, RD + 2);
        end
        checks++;
        if (snes_rdata !== 8'hAB) begin
            failures++;
            $display("FAIL read_data got=%h exp=AB", snes_rdata);
        end
        checks++;
        if (oe_low != RD) begin
            failures++;
            $display("FAIL read_oe_cycles got=%0d exp=%0d", oe_low, RD);
        end
        step();
        checks++;
        if (snes_done !== 1'b0) begin
            failures++;
            $display("FAIL read_done_pulse got=%b exp=0", snes_done);
        end
    endtask

    // Drives one SNES write to 0xE00010 and observes the pin sequence
    task automatic run_snes_write(input logic writable, input logic [7:0] wd,
                                  output int we_low, output int oe_low, output int done_cyc,
                                  output int rise_cyc, output logic oe_first,
                                  output logic oe_at_rise, output logic oe_after, output logic bus_bad);
        wait_idle();
        snes_addr = 24'hE00010; snes_wdata = wd; snes_we = 1'b1; snes_writable = writable;
        snes_req = 1'b1;
        step();
        snes_req = 1'b0; snes_we = 1'b0;
        we_low = 0; oe_low = 0; done_cyc = -1; rise_cyc = -1;
        oe_first = rom_dq_oe; oe_at_rise = 1'bx; oe_after = 1'bx; bus_bad = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (!rom_oe_n) oe_low++;
            if (!rom_we_n) begin
                we_low++;
                if (rom_dq_out !== {wd, wd} || rom_ble_n !== 1'b0 || rom_bhe_n !== 1'b1 || rom_dq_oe !== 1'b1)
                    bus_bad = 1'b1;
            end else if (we_low > 0 && rise_cyc < 0) begin
                rise_cyc = c;
                oe_at_rise = rom_dq_oe;
            end
            if (rise_cyc >= 0 && c == rise_cyc + 1) oe_after = rom_dq_oe;
            if (snes_done === 1'b1 && done_cyc < 0) done_cyc = c;
            step();
        end
    endtask

    task automatic test_snes_write();
        int we_low, oe_low, done_cyc, rise_cyc;
        logic oe_first, oe_at_rise, oe_after, bus_bad;
        exp_write(24'hE00010, 8'h3C);
        run_snes_write(1'b1, 8'h3C, we_low, oe_low, done_cyc, rise_cyc, oe_first, oe_at_rise, oe_after, bus_bad);
        checks++;
        if (we_low != WR) begin failures++; $display("FAIL write_we_cycles got=%0d exp=%0d", we_low, WR); end
        checks++;
        if (bus_bad) begin failures++; $display("FAIL write_bus got dq=%h ble=%b bhe=%b exp 3C3C/0/1", rom_dq_out, rom_ble_n, rom_bhe_n); end
        checks++;
        if (oe_first !== 1'b1) begin failures++; $display("FAIL write_dqoe_first got=%b exp=1", oe_first); end
        checks++;
        if (oe_at_rise !== 1'b1 || oe_after !== 1'b0) begin
            failures++;
            $display("FAIL write_dqoe_drop got rise=%b after=%b exp 1/0", oe_at_rise, oe_after);
        end
        checks++;
        if (done_cyc != WR + 2 || rise_cyc != WR + 2) begin
            failures++;
            $display("FAIL write_done_cycle got done=%0d rise=%0d exp %0d", done_cyc, rise_cyc, WR + 2);
        end
        checks++;
        if (mem[8'h08] !== exp_mem[8'h08]) begin
            failures++;
            $display("FAIL write_mem got=%h exp=%h", mem[8'h08], exp_mem[8'h08]);
        end
    endtask

    task automatic test_write_protect();
        int we_low, oe_low, done_cyc, rise_cyc;
        logic oe_first, oe_at_rise, oe_after, bus_bad;
        run_snes_write(1'b0, 8'hC3, we_low, oe_low, done_cyc, rise_cyc, oe_first, oe_at_rise, oe_after, bus_bad);
        checks++;
        if (we_low != 0) begin failures++; $display("FAIL wp_we got=%0d exp=0", we_low); end
        checks++;
        if (oe_low != RD) begin failures++; $display("FAIL wp_read_cycles got=%0d exp=%0d", oe_low, RD); end
        checks++;
        if (done_cyc != RD + 2) begin failures++; $display("FAIL wp_done got=%0d exp=%0d", done_cyc, RD + 2); end
        checks++;
        if (mem[8'h08] !== exp_mem[8'h08]) begin
            failures++;
            $display("FAIL wp_mem got=%h exp=%h", mem[8'h08], exp_mem[8'h08]);
        end
    endtask

    task automatic test_simultaneous();
        int d_cyc, a_cyc;
        logic [7:0] d_dat, a_dat;
        wait_idle();
        snes_addr = 24'h000040; snes_we = 1'b0; snes_writable = 1'b1;
        sa1_addr = 24'h000087; sa1_we = 1'b0;
        snes_req = 1'b1; sa1_req = 1'b1;
        step();
        snes_req = 1'b0;
        d_cyc = -1; a_cyc = -1; d_dat = 8'h00; a_dat = 8'h00;
        for (int c = 1; c <= 40; c++) begin
            if (snes_done === 1'b1 && d_cyc < 0) begin d_cyc = c; d_dat = snes_rdata; end
            if (sa1_ack === 1'b1 && a_cyc < 0) begin a_cyc = c; a_dat = sa1_rdata; sa1_req = 1'b0; end
            step();
        end
        sa1_req = 1'b0;
        checks++;
        if (d_cyc != RD + 2) begin failures++; $display("FAIL sim_snes_first got=%0d exp=%0d", d_cyc, RD + 2); end
        checks++;
        if (a_cyc != (RD + 2) + RC + (RD + 2)) begin
            failures++;
            $display("FAIL sim_sa1_latency got=%0d exp=%0d", a_cyc, (RD + 2) + RC + (RD + 2));
        end
        checks++;
        if (d_dat !== exp_byte(24'h000040)) begin failures++; $display("FAIL sim_snes_data got=%h exp=%h", d_dat, exp_byte(24'h000040)); end
        checks++;
        if (a_dat !== exp_byte(24'h000087)) begin failures++; $display("FAIL sim_sa1_data got=%h exp=%h", a_dat, exp_byte(24'h000087)); end
    endtask

    task automatic test_overwrite();
        int done_cnt, ack_cnt;
        logic saw10, saw20;
        logic [7:0] d_dat;
        wait_idle();
        sa1_addr = 24'h000101; sa1_we = 1'b0; sa1_req = 1'b1;
        snes_we = 1'b0; snes_writable = 1'b1;
        step();
        done_cnt = 0; ack_cnt = 0; saw10 = 1'b0; saw20 = 1'b0; d_dat = 8'h00;
        for (int c = 1; c <= 50; c++) begin
            if (!rom_ce_n && rom_addr === 23'h000008) saw10 = 1'b1;
            if (!rom_ce_n && rom_addr === 23'h000010) saw20 = 1'b1;
            if (snes_done === 1'b1) begin done_cnt++; d_dat = snes_rdata; end
            if (sa1_ack === 1'b1) begin ack_cnt++; sa1_req = 1'b0; end
            if (c == 2)      begin snes_req = 1'b1; snes_addr = 24'h000010; end
            else if (c == 4) begin snes_req = 1'b1; snes_addr = 24'h000020; end
            else             snes_req = 1'b0;
            step();
        end
        sa1_req = 1'b0;
        checks++;
        if (saw10 !== 1'b0 || saw20 !== 1'b1) begin
            failures++;
            $display("FAIL ovw_addr got saw10=%b saw20=%b exp 0/1", saw10, saw20);
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL ovw_done_count got=%0d exp=1", done_cnt); end
        checks++;
        if (ack_cnt != 1) begin failures++; $display("FAIL ovw_ack_count got=%0d exp=1", ack_cnt); end
        checks++;
        if (d_dat !== exp_byte(24'h000020)) begin failures++; $display("FAIL ovw_data got=%h exp=%h", d_dat, exp_byte(24'h000020)); end
    endtask

    task automatic test_random();
        int mode, s_lat, a_lat, s_cnt, a_cnt, s_cyc, a_cyc, a_exp_cyc;
        logic s_on, a_on, s_eff_we, s_we_r, s_wr_r, a_we_r;
        logic [23:0] s_a, a_a;
        logic [7:0] s_wd, a_wd, s_exp, a_exp, s_dat, a_dat;
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            s_on = (mode != 1); a_on = (mode != 0);
            s_a = 24'($urandom_range(0, 511)); a_a = 24'($urandom_range(0, 511));
            s_we_r = 1'($urandom_range(0, 1)); s_wr_r = 1'($urandom_range(0, 1));
            a_we_r = 1'($urandom_range(0, 1));
            s_wd = 8'($urandom_range(0, 255)); a_wd = 8'($urandom_range(0, 255));
            s_eff_we = s_we_r & s_wr_r;
            s_lat = s_eff_we ? WR + 2 : RD + 2;
            a_lat = a_we_r ? WR + 2 : RD + 2;
            a_exp_cyc = s_on ? s_lat + RC + a_lat : a_lat;
            s_exp = 8'h00; a_exp = 8'h00;
            if (s_on) begin
                if (s_eff_we) exp_write(s_a, s_wd);
                else          s_exp = exp_byte(s_a);
            end
            if (a_on) begin
                if (a_we_r) exp_write(a_a, a_wd);
                else        a_exp = exp_byte(a_a);
            end
            wait_idle();
            snes_addr = s_a; snes_we = s_we_r; snes_writable = s_wr_r; snes_wdata = s_wd;
            sa1_addr = a_a; sa1_we = a_we_r; sa1_wdata = a_wd;
            snes_req = s_on; sa1_req = a_on;
            step();
            snes_req = 1'b0;
            s_cnt = 0; a_cnt = 0; s_cyc = -1; a_cyc = -1; s_dat = 8'h00; a_dat = 8'h00;
            for (int c = 1; c <= 30; c++) begin
                if (snes_done === 1'b1) begin s_cnt++; s_cyc = c; s_dat = snes_rdata; end
                if (sa1_ack === 1'b1) begin a_cnt++; a_cyc = c; a_dat = sa1_rdata; sa1_req = 1'b0; end
                step();
            end
            sa1_req = 1'b0;
            if (s_on) begin
                checks++;
                if (s_cnt != 1 || s_cyc != s_lat) begin
                    failures++;
                    $display("FAIL rnd%0d_snes_timing got cnt=%0d cyc=%0d exp 1/%0d", it, s_cnt, s_cyc, s_lat);
                end
                if (!s_we_r) begin
                    checks++;
                    if (s_dat !== s_exp) begin failures++; $display("FAIL rnd%0d_snes_data got=%h exp=%h", it, s_dat, s_exp); end
                end
            end
            if (a_on) begin
                checks++;
                if (a_cnt != 1 || a_cyc != a_exp_cyc) begin
                    failures++;
                    $display("FAIL rnd%0d_sa1_timing got cnt=%0d cyc=%0d exp 1/%0d", it, a_cnt, a_cyc, a_exp_cyc);
                end
                if (!a_we_r) begin
                    checks++;
                    if (a_dat !== a_exp) begin failures++; $display("FAIL rnd%0d_sa1_data got=%h exp=%h", it, a_dat, a_exp); end
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_mem_contents();
        int bad, first;
        bad = 0; first = -1;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mem_contents got %0d bad words (first idx %0d) exp 0", bad, first);
        end
    endtask

    task automatic test_reset_mid();
        logic strobe_seen;
        wait_idle();
        sa1_addr = 24'h000002; sa1_we = 1'b0; sa1_req = 1'b1;
        step();
        snes_addr = 24'h000004; snes_we = 1'b0; snes_req = 1'b1;
        step();
        snes_req = 1'b0;
        step(); step();
        checks++;
        if (rom_oe_n !== 1'b0 || rom_ce_n !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_in_read got oe=%b ce=%b exp 0/0", rom_oe_n, rom_ce_n);
        end
        #2;
        rst_n = 1'b0;
        sa1_req = 1'b0;
        #1;
        checks++;
        if ({rom_ce_n, rom_oe_n, rom_we_n} !== 3'b111 || rom_dq_oe !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_strobes got ce/oe/we=%b dqoe=%b exp 111/0", {rom_ce_n, rom_oe_n, rom_we_n}, rom_dq_oe);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        step(); step();
        rst_n = 1'b1;
        strobe_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rom_ce_n !== 1'b1 || snes_done !== 1'b0 || sa1_ack !== 1'b0) strobe_seen = 1'b1;
            step();
        end
        checks++;
        if (strobe_seen) begin failures++; $display("FAIL rstmid_pend_lost got access=1 exp=0"); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = 16'($urandom);
        exp_mem[8'h91] = 16'hAB5A;
        test_reset();
        test_snes_read();
        test_snes_write();
        test_write_protect();
        test_simultaneous();
        test_overwrite();
        test_random();
        test_mem_contents();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
